ks_adder_pipe: RTL
==================

# ks_adder_pipe

Parametrised, pipelined Kogge-Stone adder/subtractor. It is the clocked successor to the fixed 8-bit combinational Kogge-Stone adder in the datapath library. It adds configurable width, optional per-prefix-level pipelining, subtract mode, carry-in, signed overflow and a valid/ready stream handshake. It sits between operand-issue logic and result writeback, and accepts one operation per cycle when unstalled.

## Interface
- WIDTH, 8: operand width in bits, ≥2. L = ceil(log2(WIDTH)) prefix levels.
- PIPE, 1: 1 = register after every prefix level; 0 = prefix tree combinational between the input and output registers.
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset; assert asynchronous, deassert synchronous to clk externally
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in; ignored when in_sub=1
- in_sub  in  1  1 = A − B, computed as A + ~B + 1
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result modulo 2^WIDTH
- out_cout  out  1  carry out of MSB; in subtract mode, 1 = no borrow (A ≥ B unsigned)
- out_ovf  out  1  two's-complement signed overflow

## Operation
- Stage 0 (input register): latches A, B' = in_sub ? ~B : B, c0 = in_sub ? 1 : in_cin, per-bit g = A&B', p = A^B'.
- Carry-in folding: bit 0 generate is g0 | (p0 & c0). Every prefix G[i] is therefore the carry into bit i+1.
- Prefix levels k = 0..L−1, distance d = 2^k. For i ≥ d: G[i] = G[i] | (P[i] & G[i−d]), P[i] = P[i] & P[i−d]. For i < d, the pair passes unchanged. Original p and c0 travel alongside as sideband.
- Output stage: sum[0] = p0 ^ c0; sum[i] = p_i ^ G[i−1]; cout = G[WIDTH−1]; ovf = carry into MSB XOR cout = G[WIDTH−2] ^ G[WIDTH−1].
- Non-power-of-two WIDTH: the top level only touches indices i ≥ d. No padding bits are visible.
- Pipeline depth D = PIPE ? L+2 : 2 register stages (input, [levels], output).
- Each stage holds a valid bit. Flow control uses a global enable: adv = out_ready | ~out_valid.
  - in_ready = adv.
  - When adv=1, every stage loads from its predecessor, including its valid bit. Stage 0 loads in_valid.
  - When adv=0, all stages hold.
- Bubbles are not squeezed out. An empty interior stage does not let upstream advance while the output is stalled.
- Transfer occurs on in_valid & in_ready (input) and on out_valid & out_ready (output).
- Data registers need no reset. Valid bits reset to 0.

## Timing
- Reset: all valid bits 0. out_valid=0; out_sum, out_cout, out_ovf = 0 (output data register is reset). in_ready=1 from the first cycle after reset because out_valid=0.
- Latency: an operand accepted at edge n appears with out_valid=1 after edge n+D−1. WIDTH=8: D=5 with PIPE=1, D=2 with PIPE=0.
- Throughput: 1 result/cycle while out_ready=1.
- Stall: out_ready=0 with out_valid=1 deasserts in_ready in the same cycle (combinational path out_ready→in_ready). out_sum, out_cout, out_ovf and out_valid stay stable until accepted.
- Simultaneous output accept and input accept in one cycle: both occur. No loss, no duplication.
- rst_n asserted mid-operation: all in-flight operations are discarded immediately. out_valid drops asynchronously. Nothing is emitted after release until new input arrives.
- in_valid=0 cycles produce bubbles that emerge D−1 cycles later as out_valid=0.

## Test plan
- WIDTH=8, PIPE=1: A=0xFF, B=0x01, sub=0, cin=0 → after 5 edges sum=0x00, cout=1, ovf=0. A=0x7F, B=0x01 → sum=0x80, cout=0, ovf=1.
- Subtract: A=0x00, B=0x01, sub=1 → sum=0xFF, cout=0 (borrow), ovf=0. A=0x80, B=0x01, sub=1 → sum=0x7F, cout=1, ovf=1. cin=1 with sub=1 must not change either result.
- Carry-in ripple: A=0xFF, B=0x00, cin=1 → sum=0x00, cout=1. Repeat at WIDTH=13 (A=0x1FFF) → sum=0, cout=1.
- Backpressure: stream 20 random ops with out_ready toggled by a 50% random pattern. Results must arrive in order, match a reference model, and have no drops or duplicates. in_ready must equal out_ready | ~out_valid on every cycle.
- Reset mid-stream: 3 ops in flight, pulse rst_n low mid-cycle → out_valid=0 immediately and none of the 3 ops ever appear. A new op after release returns exactly D−1 cycles after its accept.
- Random regression over WIDTH ∈ {2,8,13,32,64} × PIPE ∈ {0,1}: 10k ops each with random valid/ready. Check sum, cout, ovf against an integer model, and check measured latency = D−1 under no stall.

Source files
------------

// File: rtl/ks_adder_pipe_if.sv
// Operand/result stream bundle for ks_adder_pipe: valid/ready on both sides.
interface ks_adder_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with carry-in folded into bit 0 generate,
// optional register per prefix level and a single global stall enable.
module ks_adder_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter bit          PIPE  = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  ks_adder_pipe_if.slave bus
);
  localparam int unsigned L = $clog2(WIDTH);

  logic adv;
  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  logic [WIDTH-1:0] b_eff, g_in, p_in;
  logic             c_in;

  always_comb begin
    b_eff   = bus.in_sub ? ~bus.in_b : bus.in_b;
    c_in    = bus.in_sub | bus.in_cin;
    p_in    = bus.in_a ^ b_eff;
    g_in    = bus.in_a & b_eff;
    g_in[0] = g_in[0] | (p_in[0] & c_in);
  end

  logic [WIDTH-1:0] s0_g, s0_p;
  logic             s0_c, s0_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   s0_v <= 1'b0;
    else if (adv) s0_v <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s0_g <= g_in;
      s0_p <= p_in;
      s0_c <= c_in;
    end
  end

  // Each level reads its predecessor by hierarchical name so every stage stays a distinct signal;
  // group propagate is not carried out of the last level because nothing consumes it.
  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int unsigned DIST = 1 << k;

    logic [WIDTH-1:0] g_i, p_i, s_i, g_n, g_o, s_o;
    logic             c_i, v_i, c_o, v_o;

    if (k == 0) begin : g_src
      assign g_i = s0_g;
      assign p_i = s0_p;
      assign s_i = s0_p;
      assign c_i = s0_c;
      assign v_i = s0_v;
    end else begin : g_src
      assign g_i = g_lvl[k-1].g_o;
      assign p_i = g_lvl[k-1].g_prop.p_o;
      assign s_i = g_lvl[k-1].s_o;
      assign c_i = g_lvl[k-1].c_o;
      assign v_i = g_lvl[k-1].v_o;
    end

    always_comb begin
      g_n = g_i;
      for (int unsigned i = DIST; i < WIDTH; i++) begin
        g_n[i] = g_i[i] | (p_i[i] & g_i[i-DIST]);
      end
    end

    if (PIPE) begin : g_ff
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   v_o <= 1'b0;
        else if (adv) v_o <= v_i;
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          g_o <= g_n;
          s_o <= s_i;
          c_o <= c_i;
        end
      end
    end else begin : g_wire
      assign g_o = g_n;
      assign s_o = s_i;
      assign c_o = c_i;
      assign v_o = v_i;
    end

    if (k + 1 < L) begin : g_prop
      logic [WIDTH-1:0] p_n, p_o;

      always_comb begin
        p_n = p_i;
        for (int unsigned i = DIST; i < WIDTH; i++) begin
          p_n[i] = p_i[i] & p_i[i-DIST];
        end
      end

      if (PIPE) begin : g_ff
        always_ff @(posedge clk) begin
          if (adv) p_o <= p_n;
        end
      end else begin : g_wire
        assign p_o = p_n;
      end
    end
  end

  logic [WIDTH-1:0] g_f, s_f;
  logic             c_f, v_f;

  assign g_f = g_lvl[L-1].g_o;
  assign s_f = g_lvl[L-1].s_o;
  assign c_f = g_lvl[L-1].c_o;
  assign v_f = g_lvl[L-1].v_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_cout  <= 1'b0;
      bus.out_ovf   <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= v_f;
      bus.out_sum   <= s_f ^ {g_f[WIDTH-2:0], c_f};
      bus.out_cout  <= g_f[WIDTH-1];
      bus.out_ovf   <= g_f[WIDTH-2] ^ g_f[WIDTH-1];
    end
  end
endmodule
